// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the front end.
//   word_t        : 32-bit machine word
//   HALT_INST     : encoding that stops the fetch stream
//   fetch_state_e : fetch unit FSM states
//   align_word()  : force an address onto a 4-byte boundary
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t HALT_INST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FULL   = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  function automatic word_t align_word(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO holding {instruction, pc} pairs.
// Entry 0 is always the head, so the head outputs come straight from
// registers and never move while the head is not dequeued.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   flush_i          : drop all entries (wins over enq/deq)
//   enq_i            : push enq_inst_i / enq_pc_i
//   deq_i            : pop the head
//   count_o          : number of valid entries (0..2)
//   head_inst_o/pc_o : head entry
module fetch_buffer
  import cpu_types_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       enq_i,
  input  word_t      enq_inst_i,
  input  word_t      enq_pc_i,
  input  logic       deq_i,
  output logic [1:0] count_o,
  output word_t      head_inst_o,
  output word_t      head_pc_o
);

  logic [1:0] count_q;
  word_t      inst0_q, pc0_q, inst1_q, pc1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count_q <= 2'd0;
    end else begin
      unique case ({enq_i, deq_i})
        2'b10: begin
          if (count_q == 2'd0) begin
            inst0_q <= enq_inst_i;
            pc0_q   <= enq_pc_i;
          end else begin
            inst1_q <= enq_inst_i;
            pc1_q   <= enq_pc_i;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          inst0_q <= inst1_q;
          pc0_q   <= pc1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Count unchanged; the new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            inst0_q <= enq_inst_i;
            pc0_q   <= enq_pc_i;
          end else begin
            inst0_q <= inst1_q;
            pc0_q   <= pc1_q;
            inst1_q <= enq_inst_i;
            pc1_q   <= enq_pc_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign count_o     = count_q;
  assign head_inst_o = inst0_q;
  assign head_pc_o   = pc0_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned reads, buffers up to two
// returned instructions, handles redirects and a sticky halt.
//   CLK, RST              : clock, synchronous active-high reset
//   imemREN/imemaddr      : memory read request and address (PC register)
//   ihit/imemload         : memory returns imemload for imemaddr this cycle
//   inst_valid/inst/...   : head of the instruction buffer, inst_npc = pc+4
//   inst_ready            : consumer takes the head this cycle
//   redirect/redirect_pc  : flush and restart fetching at redirect_pc
//   halt                  : the halt word has been consumed (sticky)
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT   = 32'h0,
  parameter int    BUF_DEPTH = 2
) (
  input  logic  CLK,
  input  logic  RST,
  output logic  imemREN,
  output word_t imemaddr,
  input  logic  ihit,
  input  word_t imemload,
  output logic  inst_valid,
  output word_t inst,
  output word_t inst_pc,
  output word_t inst_npc,
  input  logic  inst_ready,
  input  logic  redirect,
  input  word_t redirect_pc,
  output logic  halt
);

  localparam logic [1:0] DEPTH_C = 2'(BUF_DEPTH);

  fetch_state_e state_q;
  word_t        pc_q;
  logic         halt_q;
  logic [1:0]   cnt;
  word_t        head_inst, head_pc;
  logic         redir, ren, enq, head_vld, deq;

  // Once the halt word has been consumed the core is parked; only RST
  // restarts it, so redirect is ignored from then on.
  assign redir    = redirect && !halt_q;
  assign ren      = (state_q == FETCH) && !RST;
  assign enq      = ren && ihit && !redir;
  assign head_vld = (cnt != 2'd0) && !RST;
  assign deq      = head_vld && inst_ready && !redir;

  fetch_buffer u_buf (
    .clk_i       (CLK),
    .rst_i       (RST),
    .flush_i     (redir),
    .enq_i       (enq),
    .enq_inst_i  (imemload),
    .enq_pc_i    (pc_q),
    .deq_i       (deq),
    .count_o     (cnt),
    .head_inst_o (head_inst),
    .head_pc_o   (head_pc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      halt_q  <= 1'b0;
    end else if (redir) begin
      state_q <= FETCH;
      pc_q    <= align_word(redirect_pc);
    end else begin
      if (deq && head_inst == HALT_INST) halt_q <= 1'b1;
      // The halt word's own fetch still advances PC; after that no fetch
      // happens in HALTED, so PC stays put.
      if (enq) pc_q <= pc_q + 32'd4;
      unique case (state_q)
        FETCH: begin
          if (enq && imemload == HALT_INST)
            state_q <= HALTED;
          else if (enq && !deq && cnt == DEPTH_C - 2'd1)
            state_q <= FULL;
        end
        FULL:    if (deq) state_q <= FETCH;
        HALTED:  ;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign imemREN    = ren;
  assign imemaddr   = pc_q;
  assign inst_valid = head_vld;
  assign inst       = head_inst;
  assign inst_pc    = head_pc;
  assign inst_npc   = head_pc + 32'd4;
  assign halt       = halt_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST, ihit, inst_ready, redirect;
  logic        imemREN, inst_valid, halt;
  logic [31:0] imemaddr, imemload, inst, inst_pc, inst_npc, redirect_pc;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  fetch_unit #(.PC_INIT(32'h40), .BUF_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_npc(inst_npc),
    .inst_ready(inst_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h00:        return 32'h1022_0003;
      32'h04:        return 32'h1422_0002;
      32'h08:        return 32'h0040_0008;
      32'h0C:        return 32'h2000_000C;
      32'h10:        return 32'h2000_0010;
      32'h14:        return 32'h3C01_0014;
      32'h20:        return 32'h2400_0020;
      32'h24:        return 32'h2400_0024;
      32'h28:        return 32'hFFFF_FFFF;
      32'h40:        return 32'h4040_4040;
      32'hFFFF_FFFC: return 32'hABCD_0001;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign imemload = mem_rd(imemaddr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // reset state
    tick();
    chk("rst_ren",   {31'b0, imemREN},    32'h0);
    chk("rst_vld",   {31'b0, inst_valid}, 32'h0);
    chk("rst_halt",  {31'b0, halt},       32'h0);
    chk("rst_addr",  imemaddr,            32'h40);
    RST = 1'b0;
    tick();
    chk("post_ren",  {31'b0, imemREN},    32'h1);
    chk("post_addr", imemaddr,            32'h40);

    // move to address 0 for streaming
    redirect = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    chk("redir0_addr", imemaddr, 32'h0);

    // streaming, one per cycle
    ihit = 1'b1; inst_ready = 1'b1;
    tick();
    chk("s0_vld", {31'b0, inst_valid}, 32'h1);
    chk("s0_inst", inst, 32'h1022_0003);
    chk("s0_pc", inst_pc, 32'h0);
    chk("s0_npc", inst_npc, 32'h4);
    tick();
    chk("s1_inst", inst, 32'h1422_0002);
    chk("s1_pc", inst_pc, 32'h4);
    chk("s1_npc", inst_npc, 32'h8);
    tick();
    chk("s2_inst", inst, 32'h0040_0008);
    chk("s2_pc", inst_pc, 32'h8);
    chk("s2_npc", inst_npc, 32'hC);
    ihit = 1'b0;
    tick();
    chk("drain_vld", {31'b0, inst_valid}, 32'h0);
    chk("drain_addr", imemaddr, 32'hC);

    // backpressure
    redirect = 1'b1; redirect_pc = 32'h0; inst_ready = 1'b0;
    tick();
    redirect = 1'b0; ihit = 1'b1;
    tick(); tick();
    chk("bp_full_ren", {31'b0, imemREN}, 32'h0);
    chk("bp_full_addr", imemaddr, 32'h8);
    tick(); tick();
    chk("bp_ren", {31'b0, imemREN}, 32'h0);
    chk("bp_addr", imemaddr, 32'h8);
    chk("bp_inst", inst, 32'h1022_0003);
    chk("bp_pc", inst_pc, 32'h0);
    chk("bp_vld", {31'b0, inst_valid}, 32'h1);
    inst_ready = 1'b1;
    tick();
    chk("rel1_inst", inst, 32'h1422_0002);
    chk("rel1_pc", inst_pc, 32'h4);
    tick();
    chk("rel2_inst", inst, 32'h0040_0008);
    chk("rel2_pc", inst_pc, 32'h8);
    tick();
    chk("rel3_inst", inst, 32'h2000_000C);
    chk("rel3_pc", inst_pc, 32'hC);

    // redirect with two entries buffered and ihit high
    inst_ready = 1'b0;
    tick();
    chk("pre_redir_full", {31'b0, imemREN}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h16;
    tick();
    redirect = 1'b0;
    chk("redir_vld", {31'b0, inst_valid}, 32'h0);
    chk("redir_addr", imemaddr, 32'h14);
    chk("redir_ren", {31'b0, imemREN}, 32'h1);
    inst_ready = 1'b1;
    tick();
    chk("redir_inst", inst, 32'h3C01_0014);
    chk("redir_pc", inst_pc, 32'h14);

    // redirect in FETCH drops the same-cycle hit and head
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    chk("redirf_vld", {31'b0, inst_valid}, 32'h0);
    chk("redirf_addr", imemaddr, 32'h20);

    // halt
    tick();
    chk("h0_pc", inst_pc, 32'h20);
    tick();
    chk("h1_pc", inst_pc, 32'h24);
    tick();
    chk("h2_ren", {31'b0, imemREN}, 32'h0);
    chk("h2_inst", inst, 32'hFFFF_FFFF);
    chk("h2_pc", inst_pc, 32'h28);
    chk("h2_halt", {31'b0, halt}, 32'h0);
    tick();
    chk("h3_halt", {31'b0, halt}, 32'h1);
    chk("h3_vld", {31'b0, inst_valid}, 32'h0);
    chk("h3_ren", {31'b0, imemREN}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    chk("h4_halt", {31'b0, halt}, 32'h1);
    chk("h4_addr", imemaddr, 32'h2C);
    chk("h4_ren", {31'b0, imemREN}, 32'h0);

    // reset while halted
    RST = 1'b1; ihit = 1'b0;
    tick();
    chk("hr_halt", {31'b0, halt}, 32'h0);
    chk("hr_vld", {31'b0, inst_valid}, 32'h0);
    chk("hr_ren", {31'b0, imemREN}, 32'h0);
    chk("hr_addr", imemaddr, 32'h40);
    RST = 1'b0; ihit = 1'b1;
    tick();
    chk("hr_inst", inst, 32'h4040_4040);
    chk("hr_pc", inst_pc, 32'h40);

    // wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; ihit = 1'b0;
    tick();
    redirect = 1'b0; ihit = 1'b1; inst_ready = 1'b0;
    tick();
    ihit = 1'b0;
    chk("wrap_inst", inst, 32'hABCD_0001);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_npc", inst_npc, 32'h0);
    chk("wrap_addr", imemaddr, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0, meaning the fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the instruction buffer entries; fixed at 2 in this revision.
REQ-003 SHALL have port CLK  in  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port imemREN  out  1  instruction memory read request.
REQ-006 SHALL have port imemaddr  out  32  fetch address, word-aligned.
REQ-007 SHALL have port ihit  in  1  memory returns imemload this cycle for imemaddr.
REQ-008 SHALL have port imemload  in  32  instruction word from memory.
REQ-009 SHALL have port inst_valid  out  1  buffer head holds an instruction.
REQ-010 SHALL have port inst  out  32  head instruction word.
REQ-011 SHALL have port inst_pc  out  32  address of the head instruction.
REQ-012 SHALL have port inst_npc  out  32  inst_pc + 4, modulo 2^32.
REQ-013 SHALL have port inst_ready  in  1  the consumer accepts the head this cycle.
REQ-014 SHALL have port redirect  in  1  branch/jump taken; flush and refetch.
REQ-015 SHALL have port redirect_pc  in  32  new fetch address.
REQ-016 SHALL have port halt  out  1  halt instruction consumed; sticky.

Function
REQ-017 SHALL run an FSM with states FETCH, FULL, and HALTED.
REQ-018 SHALL assert imemREN only in FETCH, and drive imemaddr from the PC register in all states.
REQ-019 SHALL, on imemREN && ihit, enqueue {imemload, PC} and advance PC by 4; 32'hFFFFFFFC wraps to 0.
REQ-020 SHALL give a latency of one cycle from the ihit cycle to inst_valid, sustaining one instruction per cycle when ihit is constant high.
REQ-021 SHALL dequeue the head on inst_valid && inst_ready; simultaneous enqueue and dequeue SHALL keep the count unchanged and preserve order.
REQ-022 SHALL transition FETCH->FULL when the count reaches BUF_DEPTH with no dequeue, and FULL->FETCH on any dequeue.
REQ-023 SHALL, on enqueuing 32'hFFFFFFFF (halt), enter HALTED, drop imemREN, and freeze PC.
REQ-024 SHALL set halt the cycle after the halt word is dequeued; halt then stays at 1 until RST.
REQ-025 SHALL give redirect priority over all other events: flush the buffer, discard any same-cycle ihit data and the same-cycle head, load PC with {redirect_pc[31:2], 2'b00}, and enter FETCH.
REQ-026 SHALL treat redirect in HALTED as a full redirect while halt = 0, and ignore redirect once halt = 1.
REQ-027 SHALL keep inst, inst_pc, and inst_npc stable while inst_valid && !inst_ready.
REQ-028 SHALL ignore ihit when imemREN = 0.

Reset
REQ-029 SHALL, when RST = 1 at a clock edge, set PC = PC_INIT, empty the buffer, set state FETCH, and clear halt; this overrides redirect and ihit.
REQ-030 SHALL hold imemREN = 0 and inst_valid = 0 during the RST cycle, with imemaddr = PC_INIT from the first cycle after reset.
REQ-031 SHALL treat RST mid-operation, including in HALTED, identically to power-up reset.

Structure
REQ-032 SHALL take word_t from the shared cpu_types_pkg.
REQ-033 SHALL place the HALT_INST constant (32'hFFFFFFFF) and the fetch state enum in cpu_types_pkg.
REQ-034 SHALL implement the buffer as sub-module fetch_buffer (2-entry FIFO with a flush input, count output, and head output registers).

Verification
REQ-035 SHALL cover streaming: ihit = 1 constantly, inst_ready = 1, memory returning words 0x10220003, 0x14220002, 0x00400008 -> inst presents them on consecutive cycles with inst_pc = 0, 4, 8 and inst_npc = 4, 8, 12.
REQ-036 SHALL cover backpressure: inst_ready = 0 for 4 cycles -> after 2 fetches imemREN = 0 and imemaddr = 8; the head stays 0x10220003/PC 0; on release, order is preserved with no loss or duplicate.
REQ-037 SHALL cover redirect: redirect = 1 with redirect_pc = 0x16 while the buffer holds 2 entries and ihit = 1 -> the next cycle has buffer empty, imemaddr = 0x14, and the discarded word never appears on inst.
REQ-038 SHALL cover halt: memory returns 0xFFFFFFFF at address 0x28 -> imemREN drops the cycle after; halt = 1 the cycle after the halt word is dequeued; a later redirect = 1 leaves halt = 1 and PC frozen.
REQ-039 SHALL cover reset mid-stream: RST = 1 in HALTED with PC_INIT = 0x40 -> the next cycle has halt = 0, inst_valid = 0, and imemaddr = 0x40, and the first imemREN && ihit fetches from 0x40.
REQ-040 SHALL cover wrap: redirect_pc = 0xFFFFFFFC then a hit -> inst_pc = 0xFFFFFFFC, inst_npc = 0, and the next imemaddr = 0.
